// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state encoding, funct3 codes and access sizing.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    RESP = 3'd5
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Bytes touched by an access; 0 marks an illegal funct3.
  function automatic logic [2:0] access_size(
    input logic [2:0] f3
  );
    logic [2:0] sz;
    sz = 3'd0;
    unique case (1'b1)
      (f3 == F3_B) || (f3 == F3_BU): sz = 3'd1;
      (f3 == F3_H) || (f3 == F3_HU): sz = 3'd2;
      (f3 == F3_W):                  sz = 3'd4;
      default:                       sz = 3'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the load/store unit.
// Gathers load bytes across two words and merges store bytes into them.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic        sext_i,
  input  logic [7:0]  buf0_i [0:3],
  input  logic [7:0]  buf1_i [0:3],
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [7:0]  wr0_o [0:3],
  output logic [7:0]  wr1_o [0:3]
);

  logic [7:0] cat [0:7];
  logic [7:0] g   [0:3];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cat[i]     = buf0_i[i];
      cat[i + 4] = buf1_i[i];
    end
    for (int i = 0; i < 4; i++) begin
      g[i] = cat[{1'b0, off_i} + 3'(i)];
    end
  end

  always_comb begin
    ld_o = {g[3], g[2], g[1], g[0]};
    unique case (size_i)
      3'd1: ld_o = {{24{sext_i & g[0][7]}}, g[0]};
      3'd2: ld_o = {{16{sext_i & g[1][7]}}, g[1], g[0]};
      default: ld_o = {g[3], g[2], g[1], g[0]};
    endcase
  end

  // Lane j of W0 takes store byte j-off; lane j of W1 takes byte j+4-off.
  always_comb begin
    logic [2:0] k0;
    logic [2:0] k1;
    for (int j = 0; j < 4; j++) begin
      k0 = 3'(j) - {1'b0, off_i};
      k1 = 3'(j) + 3'd4 - {1'b0, off_i};
      wr0_o[j] = buf0_i[j];
      wr1_o[j] = buf1_i[j];
      if ((2'(j) >= off_i) && (k0 < size_i))
        wr0_o[j] = wdata_i[{k0[1:0], 3'b000} +: 8];
      if (k1 < size_i)
        wr1_o[j] = wdata_i[{k1[1:0], 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory front end: RV32I loads/stores with split accesses.
// Sub-word stores use read-modify-write since memory lacks byte enables.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_out [0:3],
  output logic [7:0]  mem_data_in [0:3],
  output logic        mem_write_en
);

  lsu_state_t state_q, state_d;

  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  buf0_q [0:3];
  logic [7:0]  buf1_q [0:3];
  logic [7:0]  buf0_d [0:3];
  logic [7:0]  buf1_d [0:3];
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  size, req_size;
  logic        split, req_ill, sext;
  logic [31:0] w0, w1, ld_val;
  logic [7:0]  wr0 [0:3];
  logic [7:0]  wr1 [0:3];

  assign size     = access_size(f3_q);
  assign req_size = access_size(req_func3);
  assign req_ill  = (req_size == 3'd0) ||
                    (req_store && (req_func3 > F3_W));
  assign split    = ({2'b00, addr_q[1:0]} +
                     {1'b0, size}) > 4'd4;
  assign sext     = (f3_q == F3_B) || (f3_q == F3_H);
  assign w0       = {addr_q[31:2], 2'b00};
  assign w1       = w0 + 32'd4;

  // Fresh read data feeds the aligner in the cycle it is captured.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (state_q == RD0) buf0_d = mem_data_out;
    if (state_q == RD1) buf1_d = mem_data_out;
  end

  lsu_align u_align (
    .off_i   (addr_q[1:0]),
    .size_i  (size),
    .sext_i  (sext),
    .buf0_i  (buf0_d),
    .buf1_i  (buf1_d),
    .wdata_i (wdata_q),
    .ld_o    (ld_val),
    .wr0_o   (wr0),
    .wr1_o   (wr1)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_ill)
            state_d = RESP;
          else if (req_store && (req_func3 == F3_W) &&
                   (req_addr[1:0] == 2'b00))
            state_d = WR0;
          else
            state_d = RD0;
        end
      end
      RD0: begin
        if (split)        state_d = RD1;
        else if (store_q) state_d = WR0;
        else              state_d = RESP;
      end
      RD1:  state_d = store_q ? WR0 : RESP;
      WR0:  state_d = split ? WR1 : RESP;
      WR1:  state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_addr     = 32'h0;
    mem_write_en = 1'b0;
    mem_data_in  = '{default: 8'h00};
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      RD0:  mem_addr  = w0;
      RD1:  mem_addr  = w1;
      WR0: begin
        mem_addr     = w0;
        mem_data_in  = wr0;
        mem_write_en = 1'b1;
      end
      WR1: begin
        mem_addr     = w1;
        mem_data_in  = wr1;
        mem_write_en = 1'b1;
      end
      RESP: resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if ((state_q == IDLE) && req_valid) begin
      store_q <= req_store;
      f3_q    <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Only an illegal request can jump straight from IDLE to RESP.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_d == RESP) begin
      if (state_q == IDLE) begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
      end else begin
        rdata_d = store_q ? 32'h0 : ld_val;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      buf0_q  <= '{default: 8'h00};
      buf1_q  <= '{default: 8'h00};
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array memory model.
// Expected values are hand-computed little-endian results.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_out [0:3];
  logic [7:0]  mem_data_in [0:3];
  logic        mem_write_en;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_func3    (req_func3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en)
  );

  // Word memory indexed by addr[9:2]; also logs writes.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_val = 32'h0;
  logic        wr_clr = 1'b1;
  int          wr_cnt;
  logic        addr_seen;
  logic [31:0] wr_a [0:3];
  logic [31:0] wr_d [0:3];
  logic [31:0] rword, din;

  assign rword = mem[mem_addr[9:2]];
  assign mem_data_out[0] = rword[7:0];
  assign mem_data_out[1] = rword[15:8];
  assign mem_data_out[2] = rword[23:16];
  assign mem_data_out[3] = rword[31:24];
  assign din = {mem_data_in[3], mem_data_in[2],
                mem_data_in[1], mem_data_in[0]};

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_idx] <= pl_val;
    else if (mem_write_en)
      mem[mem_addr[9:2]] <= din;
    if (wr_clr) begin
      wr_cnt    <= 0;
      addr_seen <= 1'b0;
    end else begin
      if (mem_write_en) begin
        if (wr_cnt < 4) begin
          wr_a[wr_cnt[1:0]] <= mem_addr;
          wr_d[wr_cnt[1:0]] <= din;
        end
        wr_cnt <= wr_cnt + 1;
      end
      if (mem_addr != 32'h0) addr_seen <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a,
                         input logic [31:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = a[9:2];
    pl_val = v;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Issue one request, return latency and sampled response.
  task automatic run(input logic st,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic hold,
                     output int lat,
                     output logic [31:0] rd,
                     output logic er);
    lat = 0;
    rd  = 32'hx;
    er  = 1'bx;
    @(negedge clk);
    wr_clr = 1'b1;
    @(negedge clk);
    wr_clr    = 1'b0;
    req_valid = 1'b1;
    req_store = st;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst_b     = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_func3 = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(mem_write_en), 32'h0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'h1);
    chk("idle_rvalid", 32'(resp_valid), 32'h0);
    chk("idle_err", 32'(resp_err), 32'h0);
    chk("idle_rdata", resp_rdata, 32'h0);
    chk("idle_addr", mem_addr, 32'h0);
    chk("idle_din", din, 32'h0);

    preload(32'h100, 32'h8899AABB);
    preload(32'h200, 32'hDEADBEEF);
    preload(32'hFFFFFFFC, 32'h0);
    preload(32'h0, 32'h0);

    run(1'b0, F3_B, 32'h101, 32'h0, 1'b0, lat, rd, er);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_data", rd, 32'hFFFFFFAA);
    chk("lb_err", 32'(er), 32'h0);

    run(1'b0, F3_BU, 32'h101, 32'h0, 1'b0, lat, rd, er);
    chk("lbu_data", rd, 32'h000000AA);

    run(1'b0, F3_H, 32'h101, 32'h0, 1'b0, lat, rd, er);
    chk("lh_lat", 32'(lat), 32'd2);
    chk("lh_data", rd, 32'hFFFF99AA);

    // Reset while in RD0 of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_func3 = F3_B;
    req_addr  = 32'h202;
    req_wdata = 32'h5A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rd0_addr", mem_addr, 32'h200);
    rst_b = 1'b0;
    #1;
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    chk("arst_we", 32'(mem_write_en), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h1);
    chk("arst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("arst_mem", mem[8'h80], 32'hDEADBEEF);

    run(1'b1, F3_B, 32'h202, 32'h5A, 1'b0, lat, rd, er);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_wcnt", 32'(wr_cnt), 32'd1);
    chk("sb_waddr", wr_a[0], 32'h200);
    chk("sb_wdata", wr_d[0], 32'hDE5ABEEF);
    chk("sb_rdata", rd, 32'h0);

    run(1'b1, F3_H, 32'hFFFFFFFF, 32'hBEEF, 1'b0,
        lat, rd, er);
    chk("sh_lat", 32'(lat), 32'd5);
    chk("sh_wcnt", 32'(wr_cnt), 32'd2);
    chk("sh_waddr0", wr_a[0], 32'hFFFFFFFC);
    chk("sh_wdata0", wr_d[0], 32'hEF000000);
    chk("sh_waddr1", wr_a[1], 32'h0);
    chk("sh_wdata1", wr_d[1], 32'h000000BE);

    preload(32'h100, 32'h44332211);
    preload(32'h104, 32'h88776655);
    run(1'b0, F3_W, 32'h103, 32'h0, 1'b0, lat, rd, er);
    chk("lw_split_lat", 32'(lat), 32'd3);
    chk("lw_split_data", rd, 32'h77665544);
    chk("lw_split_wcnt", 32'(wr_cnt), 32'd0);

    run(1'b1, F3_W, 32'h200, 32'h12345678, 1'b0,
        lat, rd, er);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wcnt", 32'(wr_cnt), 32'd1);
    chk("sw_wdata", wr_d[0], 32'h12345678);

    run(1'b0, F3_HU, 32'h202, 32'h0, 1'b0, lat, rd, er);
    chk("lhu_data", rd, 32'h00001234);

    run(1'b0, 3'd3, 32'h100, 32'h0, 1'b0, lat, rd, er);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_err", 32'(er), 32'h1);
    chk("ill_rdata", rd, 32'h0);
    chk("ill_wcnt", 32'(wr_cnt), 32'd0);
    chk("ill_addr", 32'(addr_seen), 32'h0);

    run(1'b1, F3_BU, 32'h200, 32'hFF, 1'b0, lat, rd, er);
    chk("ill_st_lat", 32'(lat), 32'd1);
    chk("ill_st_err", 32'(er), 32'h1);
    chk("ill_st_mem", mem[8'h80], 32'h12345678);

    // Request held through RD0 must not be taken twice.
    run(1'b0, F3_W, 32'h100, 32'h0, 1'b1, lat, rd, er);
    chk("hold_lat", 32'(lat), 32'd2);
    chk("hold_data", rd, 32'h44332211);
    chk("hold_err", 32'(er), 32'h0);
    @(negedge clk);
    chk("hold_ready1", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("hold_ready2", 32'(req_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
